// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and a valid/ack
// handshake towards a processor input port.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   col_out   column drive, active-low one-hot (1110, 1101, 1011, 0111)
//   row_in    row sense, active-low, asynchronous to clk
//   key_code  code of the last accepted key, row*4 + col
//   key_valid new key code available, held until key_ack
//   key_ack   one-cycle read strobe from the port decoder
//   key_down  an accepted key is currently held
//   overrun   sticky: a key was accepted while key_valid was still set
module keypad_scanner #(
  parameter int SCAN_DIV = 1024,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_out,
  input  logic [3:0] row_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overrun
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
  // Bit 4 set means "no single key" (nothing pressed, or ghosting).
  localparam logic [4:0]       CAND_NONE = 5'b1_0000;

  typedef enum logic {IDLE, PRESSED} state_t;

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [15:0]      key_map;
  logic [15:0]      frame_map;
  logic [4:0]       prev_cand;
  logic [4:0]       candidate;
  logic [4:0]       cand_cnt;
  logic [3:0]       cand_idx;
  logic [DB_W-1:0]  db_cnt;
  logic [DB_W-1:0]  db_next;
  logic             sample;
  logic             eval;
  logic             stable;

  state_t     state, state_next;
  logic [3:0] code_next;
  logic       valid_next;
  logic       down_next;
  logic       overrun_next;

  assign col_out = ~(4'b0001 << col_idx);
  assign sample  = (div == DIV_LAST);
  assign eval    = sample && (col_idx == 2'd3);

  // The key map with the current column's rows merged in, so the frame can
  // be judged on the same edge that samples column 3.
  always_comb begin
    frame_map = key_map;
    for (int r = 0; r < 4; r++) begin
      frame_map[{2'(r), col_idx}] = ~row_sync[r];
    end
  end

  // Exactly one key down gives a candidate; zero or several give NONE.
  always_comb begin
    cand_cnt = 5'd0;
    cand_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_map[i]) begin
        cand_cnt = cand_cnt + 5'd1;
        cand_idx = 4'(i);
      end
    end
    candidate = (cand_cnt == 5'd1) ? {1'b0, cand_idx} : CAND_NONE;
  end

  // Run length of identical frame candidates, saturating at DEBOUNCE.
  always_comb begin
    if (candidate != prev_cand) begin
      db_next = DB_ONE;
    end else if (db_cnt == DB_MAX) begin
      db_next = DB_MAX;
    end else begin
      db_next = db_cnt + DB_ONE;
    end
    stable = (db_next == DB_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta  <= 4'hF;
      row_sync  <= 4'hF;
      div       <= '0;
      col_idx   <= 2'd0;
      key_map   <= 16'h0000;
      prev_cand <= CAND_NONE;
      db_cnt    <= '0;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
      if (sample) begin
        div     <= '0;
        col_idx <= col_idx + 2'd1;
        key_map <= frame_map;
        if (col_idx == 2'd3) begin
          prev_cand <= candidate;
          db_cnt    <= db_next;
        end
      end else begin
        div <= div + DIV_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      key_code  <= code_next;
      key_valid <= valid_next;
      key_down  <= down_next;
      overrun   <= overrun_next;
    end
  end

  // A new acceptance overrides a simultaneous ack, and an ack on that same
  // cycle counts as the processor having read the old code (no overrun).
  always_comb begin
    state_next   = state;
    code_next    = key_code;
    valid_next   = key_valid & ~key_ack;
    down_next    = key_down;
    overrun_next = overrun;
    case (state)
      IDLE: begin
        if (eval && stable && !candidate[4]) begin
          state_next = PRESSED;
          code_next  = candidate[3:0];
          valid_next = 1'b1;
          down_next  = 1'b1;
          if (key_valid && !key_ack) begin
            overrun_next = 1'b1;
          end
        end
      end
      PRESSED: begin
        if (eval && stable && candidate[4]) begin
          state_next = IDLE;
          down_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Matrix keypad scanner for the PicoBlaze lab designs. It is the input-side counterpart of the multiplexed seven-segment driver. The display scanner writes one digit per time slot; this block drives one keypad column per time slot and reads back the row lines. It debounces the result and presents one key code per press to the processor's input port, using a valid/acknowledge handshake.

Parameters:
SCAN_DIV, 1024, clk cycles each column is driven before its rows are sampled (must be >= 4).
DEBOUNCE, 4, consecutive identical scan frames needed to accept a press or a release (>= 1).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
col_out  output  4  column drive, active-low one-hot
row_in  input  4  row sense, active-low (externally pulled up), asynchronous
key_code  output  4  code of the last accepted key = row*4 + col
key_valid  output  1  new key code available, held until acknowledged
key_ack  input  1  one-cycle pulse from the port decoder on read of key_code
key_down  output  1  an accepted key is currently held
overrun  output  1  sticky: a new key was accepted while key_valid was still 1

Behaviour:
- Reset values:
  - col_out = 4'b1110; key_code = 0; key_valid = 0; key_down = 0; overrun = 0.
  - Divider = 0, column index = 0, debounce count = 0, FSM = IDLE.
- Synchronisation:
  - row_in passes through a 2-flop synchroniser.
  - Only the synchronised value is used.
- Scan timing:
  - The divider counts 0 to SCAN_DIV-1.
  - At count SCAN_DIV-1, the synchronised rows are sampled for the current column.
  - On that same edge, the column index advances 0→1→2→3→0.
  - col_out = ~(1 << column index), so the sequence is 1110, 1101, 1011, 0111.
  - A frame is 4 columns, i.e. 4*SCAN_DIV cycles.
- Frame evaluation (on the edge that samples column 3):
  - Exactly one key pressed in the 16-bit map: candidate = that key.
  - Zero keys, or two or more keys (ghosting protection): candidate = NONE.
- Debounce:
  - The counter increments while the candidate equals the previous frame's candidate, saturating at DEBOUNCE.
  - It reloads to 1 when the candidate changes.
  - The candidate is "stable" once the count reaches DEBOUNCE.
- FSM:
  - IDLE, on a stable non-NONE candidate → PRESSED:
    - key_code <= candidate; key_valid <= 1; key_down <= 1.
    - If key_valid was already 1 and key_ack is not asserted this cycle, overrun <= 1.
  - PRESSED, on a stable NONE → IDLE: key_down <= 0.
  - PRESSED, on a different stable key: ignored. A release must be seen first.
- Handshake:
  - key_ack clears key_valid on the next edge.
  - key_ack in the same cycle as a new acceptance: the acceptance wins, key_valid stays 1, and overrun is not set.
  - key_ack while key_valid = 0 has no effect.
- overrun: sticky, cleared only by rst.
- Latency:
  - A press first sampled in frame N is accepted on the evaluation edge of frame N+DEBOUNCE-1.
  - key_valid is observable 1 cycle after that edge.
- Reset mid-scan: all state is discarded and scanning restarts at column 0 on the first cycle after rst deasserts.

Test Plan:
The bench models the keypad combinationally: key (r,c) held pulls row_in[r] low while col_out[c] = 0. Unless stated otherwise, SCAN_DIV = 4 and DEBOUNCE = 2.

1. Reset and scan sequence: release rst with no keys held → col_out is 1110 for cycles 1–4, then 1101, 1011, 0111, then repeats 1110. key_valid, key_down and overrun stay 0 for 200 cycles.
2. Single press: hold key (2,1) from reset release → key_valid rises 1 cycle after the 2nd frame evaluation edge (cycle 33) with key_code = 9 and key_down = 1. Pulse key_ack → key_valid = 0 on the next cycle while key_down stays 1. Release the key → key_down = 0 after 2 NONE frames.
3. Bounce rejection: toggle key (0,3) every frame for 6 frames, then hold it → no acceptance during toggling. key_code = 3 is accepted after 2 stable frames.
4. Ghosting and held key: hold keys (1,1) and (1,2) together → never accepted. Hold (1,1), then add (3,3) without releasing → only code 5 is reported; no second key_valid event occurs.
5. Overrun and ack race: accept code 4, release, then press code 7 without acking → key_code = 7 and overrun = 1. Repeat with key_ack asserted on the acceptance cycle → key_valid = 1 and overrun = 0.
6. Mid-operation reset: assert rst for 1 cycle while PRESSED with key_valid = 1 → all outputs return to reset values and col_out = 1110. The still-held key is re-accepted after 2 new frames.
